// File: rtl/modulo_objetivo_lineas_pkg.sv
// Shared definitions for the line-target navigation stage: state encoding,
// count width, default watchdog timeout and the modulo-256 progress helper.
package modulo_objetivo_lineas_pkg;

   localparam int ANCHO_CONTEO       = 8;
   localparam int TIMEOUT_CICLOS_DEF = 50_000_000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      AVANZANDO = 2'd1,
      LLEGADO   = 2'd2,
      ERROR     = 2'd3
   } estado_t;

   // Unsigned wrap makes a 255->0 crossing count as one line of progress.
   function automatic logic [ANCHO_CONTEO-1:0] progreso(
      input logic [ANCHO_CONTEO-1:0] conteo,
      input logic [ANCHO_CONTEO-1:0] base
   );
      return conteo - base;
   endfunction

endpackage

// File: rtl/modulo_objetivo_lineas_if.sv
// Command channel from the NIOS side: "advance N lines" over valid/ready.
interface modulo_objetivo_lineas_if;
   import modulo_objetivo_lineas_pkg::*;

   logic                    cmdValid;
   logic [ANCHO_CONTEO-1:0] cmdObjetivo;
   logic                    cmdReady;

   modport master (output cmdValid, output cmdObjetivo, input cmdReady);
   modport slave  (input cmdValid, input cmdObjetivo, output cmdReady);

endinterface

// File: rtl/modulo_objetivo_lineas_watchdog.sv
// Stall watchdog: counts cycles without a line-count change while the robot
// is advancing and flags expiry once TIMEOUT_CICLOS is reached.
module modulo_watchdog_lineas
   import modulo_objetivo_lineas_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic activo,
   input  logic cambio,
   output logic expirado
);

   localparam int ANCHO = (TIMEOUT_CICLOS < 1) ? 1 : $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [ANCHO-1:0] LIMITE = ANCHO'(TIMEOUT_CICLOS);
   localparam logic [ANCHO-1:0] UNO    = ANCHO'(1);

   logic [ANCHO-1:0] cuenta_r;

   // Idle cycle counter; held at zero outside AVANZANDO so entry starts clean
   always_ff @(posedge clock) begin
      if (reset) begin
         cuenta_r <= {ANCHO{1'b0}};
      end else if (!activo || cambio) begin
         cuenta_r <= {ANCHO{1'b0}};
      end else if (cuenta_r != LIMITE) begin
         cuenta_r <= cuenta_r + UNO;
      end else begin
         cuenta_r <= cuenta_r;
      end
   end

   assign expirado = (cuenta_r == LIMITE);

endmodule

// File: rtl/modulo_objetivo_lineas.sv
// Line-target navigation stage: drives the motor until N new line crossings
// are seen. The stall watchdog is compiled in with OBJETIVO_WATCHDOG_EN.
module modulo_objetivo_lineas
   import modulo_objetivo_lineas_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [ANCHO_CONTEO-1:0] conteo,
   modulo_objetivo_lineas_if.slave cmd,
   output logic                    avanzar,
   output logic                    done,
   output logic                    error,
   output logic [ANCHO_CONTEO-1:0] restantes
);

   estado_t                 estado_r, estado_sig_s;
   logic [ANCHO_CONTEO-1:0] base_r, base_sig_s;
   logic [ANCHO_CONTEO-1:0] objetivo_r, objetivo_sig_s;
   logic [ANCHO_CONTEO-1:0] restantes_r, restantes_sig_s;
   logic                    cmd_ready_r, avanzar_r, done_r;
   logic                    aceptar_s, cambio_s, expirado_s;

   assign aceptar_s = cmd.cmdValid && cmd_ready_r;

   // Next-state, command capture and next value of the remaining-lines output
   always_comb begin
      estado_sig_s    = estado_r;
      base_sig_s      = base_r;
      objetivo_sig_s  = objetivo_r;
      restantes_sig_s = 8'd0;
      case (estado_r)
         IDLE, ERROR: begin
            if (aceptar_s) begin
               base_sig_s     = conteo;
               objetivo_sig_s = cmd.cmdObjetivo;
               estado_sig_s   = (cmd.cmdObjetivo == 8'd0) ? LLEGADO : AVANZANDO;
            end else begin
               estado_sig_s = estado_r;
            end
         end
         AVANZANDO: begin
            // Completion wins over a simultaneous watchdog expiry
            if (progreso(conteo, base_r) == objetivo_r) begin
               estado_sig_s = LLEGADO;
            end else if (expirado_s && !cambio_s) begin
               estado_sig_s = ERROR;
            end else begin
               estado_sig_s = AVANZANDO;
            end
         end
         LLEGADO: estado_sig_s = IDLE;
         default: estado_sig_s = IDLE;
      endcase
      if (estado_sig_s == AVANZANDO) begin
         restantes_sig_s = objetivo_sig_s - progreso(conteo, base_sig_s);
      end else begin
         restantes_sig_s = 8'd0;
      end
   end

   // State and output registers; outputs are decoded from the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_r    <= IDLE;
         base_r      <= 8'd0;
         objetivo_r  <= 8'd0;
         restantes_r <= 8'd0;
         cmd_ready_r <= 1'b1;
         avanzar_r   <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         estado_r    <= estado_sig_s;
         base_r      <= base_sig_s;
         objetivo_r  <= objetivo_sig_s;
         restantes_r <= restantes_sig_s;
         cmd_ready_r <= (estado_sig_s == IDLE) || (estado_sig_s == ERROR);
         avanzar_r   <= (estado_sig_s == AVANZANDO);
         done_r      <= (estado_sig_s == LLEGADO);
      end
   end

   assign cmd.cmdReady = cmd_ready_r;
   assign avanzar      = avanzar_r;
   assign done         = done_r;
   assign restantes    = restantes_r;

`ifdef OBJETIVO_WATCHDOG_EN
   logic [ANCHO_CONTEO-1:0] conteo_prev_r;
   logic                    error_r;
   logic                    activo_s;

   // Previous count, used to detect a line crossing in the current cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         conteo_prev_r <= 8'd0;
      end else begin
         conteo_prev_r <= conteo;
      end
   end

   assign activo_s = (estado_r == AVANZANDO);
   assign cambio_s = (conteo != conteo_prev_r);

   modulo_watchdog_lineas #(
      .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .activo  (activo_s),
      .cambio  (cambio_s),
      .expirado(expirado_s)
   );

   // Sticky stall flag, cleared only by accepting a new command
   always_ff @(posedge clock) begin
      if (reset) begin
         error_r <= 1'b0;
      end else begin
         error_r <= (estado_sig_s == ERROR);
      end
   end

   assign error = error_r;
`else
   assign cambio_s   = 1'b0;
   assign expirado_s = 1'b0;
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_modulo_objetivo_lineas.sv
// Self-checking bench for modulo_objetivo_lineas; watchdog scenarios follow
// OBJETIVO_WATCHDOG_EN with a 100-cycle timeout.
module tb_modulo_objetivo_lineas;

   typedef struct {
      logic [7:0] restantes;
      logic       avanzar;
      logic       done;
   } esperado_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] conteo;
   logic       avanzar, done, error;
   logic [7:0] restantes;

   int checks = 0;
   int errors = 0;
   esperado_t sb_q[$];

   modulo_objetivo_lineas_if cmd();

   modulo_objetivo_lineas #(.TIMEOUT_CICLOS(100)) dut (
      .clock    (clock),
      .reset    (reset),
      .conteo   (conteo),
      .cmd      (cmd),
      .avanzar  (avanzar),
      .done     (done),
      .error    (error),
      .restantes(restantes)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] r, input logic a, input logic d);
      esperado_t e;
      e.restantes = r;
      e.avanzar   = a;
      e.done      = d;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (cmd.cmdReady !== 1'b1 || avanzar !== 1'b0 || done !== 1'b0 ||
          error !== 1'b0 || restantes !== 8'd0) begin
         errors++;
         $display("FAIL reset: ready=%b avanzar=%b done=%b error=%b restantes=%0d, expected 1 0 0 0 0",
                  cmd.cmdReady, avanzar, done, error, restantes);
      end
      reset = 1'b0;
      tick();
   endtask

   // Generic move starting at conteo=start with target obj, stepping one line per cycle
   task automatic test_move(input string name, input logic [7:0] start, input logic [7:0] obj);
      esperado_t e;
      conteo = start;
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = obj;
      push(obj, 1'b1, 1'b0);
      tick();
      cmd.cmdValid = 1'b0;
      cmd.cmdObjetivo = 8'd0;
      for (int i = 0; i <= int'(obj); i++) begin
         if (i > 0) begin
            push(8'(int'(obj) - i), (i < int'(obj)), (i == int'(obj)));
            tick();
         end
         e = sb_q.pop_front();
         checks++;
         if (restantes !== e.restantes || avanzar !== e.avanzar || done !== e.done || cmd.cmdReady !== 1'b0) begin
            errors++;
            $display("FAIL %s step %0d: restantes=%0d avanzar=%b done=%b ready=%b, expected %0d %b %b 0",
                     name, i, restantes, avanzar, done, cmd.cmdReady, e.restantes, e.avanzar, e.done);
         end
         if (i < int'(obj)) conteo = 8'(int'(start) + i + 1);
      end
      tick();
      checks++;
      if (done !== 1'b0 || avanzar !== 1'b0 || cmd.cmdReady !== 1'b1) begin
         errors++;
         $display("FAIL %s_end: done=%b avanzar=%b ready=%b, expected 0 0 1", name, done, avanzar, cmd.cmdReady);
      end
   endtask

   task automatic test_zero_target();
      logic saw_avanzar = 1'b0;
      conteo = 8'd40;
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = 8'd0;
      tick();
      cmd.cmdValid = 1'b0;
      saw_avanzar |= avanzar;
      checks++;
      if (done !== 1'b1 || restantes !== 8'd0 || cmd.cmdReady !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b restantes=%0d ready=%b, expected 1 0 0", done, restantes, cmd.cmdReady);
      end
      tick();
      saw_avanzar |= avanzar;
      checks++;
      if (done !== 1'b0 || cmd.cmdReady !== 1'b1 || saw_avanzar !== 1'b0) begin
         errors++;
         $display("FAIL zero_end: done=%b ready=%b avanzar_seen=%b, expected 0 1 0", done, cmd.cmdReady, saw_avanzar);
      end
   endtask

   task automatic test_interference();
      esperado_t e;
      logic saw_done = 1'b0;
      conteo = 8'd20;
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = 8'd5;
      push(8'd5, 1'b1, 1'b0);
      tick();
      cmd.cmdObjetivo = 8'd1;
      for (int i = 1; i <= 3; i++) begin
         e = sb_q.pop_front();
         checks++;
         if (restantes !== e.restantes || avanzar !== e.avanzar || done !== e.done) begin
            errors++;
            $display("FAIL ignore_cmd step %0d: restantes=%0d avanzar=%b done=%b, expected %0d %b %b",
                     i, restantes, avanzar, done, e.restantes, e.avanzar, e.done);
         end
         conteo = 8'(20 + i);
         push(8'(5 - i), 1'b1, 1'b0);
         tick();
      end
      cmd.cmdValid = 1'b0;
      sb_q.delete();
      reset = 1'b1;
      tick();
      checks++;
      if (cmd.cmdReady !== 1'b1 || avanzar !== 1'b0 || done !== 1'b0 || error !== 1'b0 || restantes !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset: ready=%b avanzar=%b done=%b error=%b restantes=%0d, expected 1 0 0 0 0",
                  cmd.cmdReady, avanzar, done, error, restantes);
      end
      reset = 1'b0;
      conteo = 8'd25;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_done |= done;
      end
      checks++;
      if (saw_done !== 1'b0 || avanzar !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: done_seen=%b avanzar=%b, expected 0 0", saw_done, avanzar);
      end
   endtask

`ifdef OBJETIVO_WATCHDOG_EN
   task automatic test_watchdog();
      int first_err = -1;
      logic early_stop = 1'b0;
      conteo = 8'd50;
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = 8'd3;
      tick();
      cmd.cmdValid = 1'b0;
      for (int t = 1; t <= 110; t++) begin
         tick();
         if (error === 1'b1 && first_err < 0) first_err = t;
         if (t < 99 && avanzar !== 1'b1) early_stop = 1'b1;
      end
      checks++;
      if (first_err < 100 || first_err > 101 || early_stop !== 1'b0) begin
         errors++;
         $display("FAIL watchdog_expiry: error at cycle %0d early_stop=%b, expected cycle 100..101 and 0",
                  first_err, early_stop);
      end
      checks++;
      if (error !== 1'b1 || avanzar !== 1'b0 || cmd.cmdReady !== 1'b1) begin
         errors++;
         $display("FAIL watchdog_state: error=%b avanzar=%b ready=%b, expected 1 0 1", error, avanzar, cmd.cmdReady);
      end
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = 8'd5;
      tick();
      cmd.cmdValid = 1'b0;
      checks++;
      if (error !== 1'b0 || avanzar !== 1'b1 || restantes !== 8'd5) begin
         errors++;
         $display("FAIL error_clear: error=%b avanzar=%b restantes=%0d, expected 0 1 5", error, avanzar, restantes);
      end
      first_err = -1;
      for (int t = 1; t <= 150; t++) begin
         tick();
         if (t == 99) conteo = 8'd51;
         if (error === 1'b1 && first_err < 0) first_err = t;
      end
      checks++;
      if (first_err >= 0 || avanzar !== 1'b1 || restantes !== 8'd4) begin
         errors++;
         $display("FAIL change_at_99: error at cycle %0d avanzar=%b restantes=%0d, expected none 1 4",
                  first_err, avanzar, restantes);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask
`else
   task automatic test_no_watchdog();
      logic saw_err = 1'b0;
      conteo = 8'd50;
      cmd.cmdValid = 1'b1;
      cmd.cmdObjetivo = 8'd3;
      tick();
      cmd.cmdValid = 1'b0;
      for (int t = 1; t <= 150; t++) begin
         tick();
         saw_err |= error;
      end
      checks++;
      if (saw_err !== 1'b0 || avanzar !== 1'b1 || restantes !== 8'd3) begin
         errors++;
         $display("FAIL no_watchdog: error_seen=%b avanzar=%b restantes=%0d, expected 0 1 3",
                  saw_err, avanzar, restantes);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask
`endif

   initial begin
      reset = 1'b1;
      conteo = 8'd0;
      cmd.cmdValid = 1'b0;
      cmd.cmdObjetivo = 8'd0;
      test_reset();
      test_move("normal", 8'd10, 8'd3);
      test_move("wrap", 8'd254, 8'd4);
      test_move("single", 8'd100, 8'd1);
      test_zero_target();
      test_interference();
`ifdef OBJETIVO_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      test_move("after_all", 8'd7, 8'd2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
